// File: rtl/msrv32_ahb_pkg.sv
// Shared definitions for the data-memory AHB-Lite master: FSM states and
// the HTRANS/HSIZE encodings that the master drives.
package msrv32_ahb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } dmem_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/msrv32_dmem_ahb_master_if.sv
// Core-side request/response and AHB-Lite bus signals of the data-memory master.
interface msrv32_dmem_ahb_master_if;
    import msrv32_ahb_pkg::*;

    logic [DATA_W-1:0] dmaddr_in;
    logic [DATA_W-1:0] dmdata_in;
    logic [3:0]        dmwr_mask_in;
    logic              dmwr_req_in;
    logic              dmrd_req_in;

    logic [DATA_W-1:0] haddr_out;
    logic [1:0]        htrans_out;
    logic              hwrite_out;
    logic [2:0]        hsize_out;
    logic [DATA_W-1:0] hwdata_out;

    logic              hready_in;
    logic              hresp_in;
    logic [DATA_W-1:0] hrdata_in;

    logic              stall_out;
    logic [DATA_W-1:0] rd_data_out;
    logic              rd_valid_out;
    logic              bus_err_out;

    modport master (
        input  dmaddr_in, dmdata_in, dmwr_mask_in, dmwr_req_in, dmrd_req_in,
        input  hready_in, hresp_in, hrdata_in,
        output haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out,
        output stall_out, rd_data_out, rd_valid_out, bus_err_out
    );

    modport slave (
        output dmaddr_in, dmdata_in, dmwr_mask_in, dmwr_req_in, dmrd_req_in,
        output hready_in, hresp_in, hrdata_in,
        input  haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out,
        input  stall_out, rd_data_out, rd_valid_out, bus_err_out
    );

endinterface

// File: rtl/msrv32_mask_decode.sv
// Byte-lane mask to AHB transfer size and low address bits; reads and
// irregular masks fall back to a full-word transfer at offset 0.
module msrv32_mask_decode
    import msrv32_ahb_pkg::*;
(
    input  logic [3:0] mask_in,
    input  logic       wr_in,
    output logic [2:0] hsize_out,
    output logic [1:0] addr_lsb_out
);

    always_comb begin
        hsize_out    = HSIZE_WORD;
        addr_lsb_out = 2'b00;
        if (wr_in) begin
            case (mask_in)
                4'b0001: begin hsize_out = HSIZE_BYTE; addr_lsb_out = 2'd0; end
                4'b0010: begin hsize_out = HSIZE_BYTE; addr_lsb_out = 2'd1; end
                4'b0100: begin hsize_out = HSIZE_BYTE; addr_lsb_out = 2'd2; end
                4'b1000: begin hsize_out = HSIZE_BYTE; addr_lsb_out = 2'd3; end
                4'b0011: begin hsize_out = HSIZE_HALF; addr_lsb_out = 2'd0; end
                4'b1100: begin hsize_out = HSIZE_HALF; addr_lsb_out = 2'd2; end
                default: begin hsize_out = HSIZE_WORD; addr_lsb_out = 2'd0; end
            endcase
        end
    end

endmodule

// File: rtl/msrv32_dmem_ahb_master.sv
// Single-outstanding AHB-Lite master for the core's load/store path:
// IDLE accepts a request, ADDR runs the address phase, DATA the data phase.
module msrv32_dmem_ahb_master
    import msrv32_ahb_pkg::*;
(
    input  logic                             ms_riscv32_mp_clk_in,
    input  logic                             ms_riscv32_mp_rst_in,
    msrv32_dmem_ahb_master_if.master         bus
);

    dmem_state_e state, state_nxt;

    logic              req_any;
    logic              accept;
    logic              addr_done;
    logic              data_done;
    logic [2:0]        dec_hsize;
    logic [1:0]        dec_lsb;

    logic [DATA_W-1:0] haddr_p0;
    logic [2:0]        hsize_p0;
    logic              hwrite_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [DATA_W-1:0] hwdata_p1;
    logic [DATA_W-1:0] rd_data_p2;
    logic              vld_p2;
    logic              err_p2;

    assign req_any = bus.dmwr_req_in | bus.dmrd_req_in;

    // Write wins when both requests are present, so decode against the write line.
    msrv32_mask_decode u_mask_decode (
        .mask_in      (bus.dmwr_mask_in),
        .wr_in        (bus.dmwr_req_in),
        .hsize_out    (dec_hsize),
        .addr_lsb_out (dec_lsb)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        addr_done = 1'b0;
        data_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_any) begin
                    accept    = 1'b1;
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus.hready_in) begin
                    addr_done = 1'b1;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.hready_in) begin
                    data_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: request captured on acceptance, drives the address phase.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            haddr_p0  <= '0;
            hsize_p0  <= '0;
            hwrite_p0 <= 1'b0;
            wdata_p0  <= '0;
        end else if (accept) begin
            haddr_p0  <= {bus.dmaddr_in[DATA_W-1:2], dec_lsb};
            hsize_p0  <= dec_hsize;
            hwrite_p0 <= bus.dmwr_req_in;
            wdata_p0  <= bus.dmdata_in;
        end
    end

    // Stage p1: write data launched for the data phase, held until the next write.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            hwdata_p1 <= '0;
        end else if (addr_done && hwrite_p0) begin
            hwdata_p1 <= wdata_p0;
        end
    end

    // Stage p2: data-phase completion; an error response suppresses read valid.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            rd_data_p2 <= '0;
            vld_p2     <= 1'b0;
            err_p2     <= 1'b0;
        end else begin
            vld_p2 <= data_done && !bus.hresp_in && !hwrite_p0;
            err_p2 <= data_done && bus.hresp_in;
            if (data_done && !bus.hresp_in && !hwrite_p0) begin
                rd_data_p2 <= bus.hrdata_in;
            end
        end
    end

    assign bus.htrans_out   = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.haddr_out    = haddr_p0;
    assign bus.hsize_out    = hsize_p0;
    assign bus.hwrite_out   = hwrite_p0;
    assign bus.hwdata_out   = hwdata_p1;
    assign bus.rd_data_out  = rd_data_p2;
    assign bus.rd_valid_out = vld_p2;
    assign bus.bus_err_out  = err_p2;
    assign bus.stall_out    = (state != ST_IDLE) || req_any;

endmodule

// File: tb/tb_msrv32_dmem_ahb_master.sv
// Scoreboard bench for msrv32_dmem_ahb_master: a queue-driven AHB slave model
// plus a negedge monitor comparing bus phases and core responses to expectations.
module tb_msrv32_dmem_ahb_master;
    import msrv32_ahb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    msrv32_dmem_ahb_master_if bus();

    msrv32_dmem_ahb_master dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .bus                  (bus)
    );

    typedef struct {
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] hwdata;
        int          hold;
    } addr_exp_t;

    typedef struct {
        logic        rv;
        logic        err;
        logic [31:0] rdata;
    } done_exp_t;

    typedef struct {
        int          aws;
        int          dws;
        logic        err;
        logic [31:0] rdata;
    } slv_cfg_t;

    addr_exp_t q_addr[$];
    done_exp_t q_done[$];
    slv_cfg_t  q_slv[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference decode of the write mask.
    function automatic logic [2:0] ref_size(input logic wr, input logic [3:0] m);
        if (!wr) return 3'b010;
        if (m == 4'b0001 || m == 4'b0010 || m == 4'b0100 || m == 4'b1000) return 3'b000;
        if (m == 4'b0011 || m == 4'b1100) return 3'b001;
        return 3'b010;
    endfunction

    function automatic logic [1:0] ref_lsb(input logic wr, input logic [3:0] m);
        if (!wr) return 2'd0;
        if (m == 4'b0010) return 2'd1;
        if (m == 4'b0100 || m == 4'b1100) return 2'd2;
        if (m == 4'b1000) return 2'd3;
        return 2'd0;
    endfunction

    task automatic push_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input int aws, input int dws,
                             input logic err, input logic [31:0] rdata);
        addr_exp_t a;
        done_exp_t d;
        slv_cfg_t  s;
        a.haddr  = {addr[31:2], ref_lsb(wr, mask)};
        a.hwrite = wr;
        a.hsize  = ref_size(wr, mask);
        a.hwdata = data;
        a.hold   = aws + 1;
        d.rv     = !wr && !err;
        d.err    = err;
        d.rdata  = rdata;
        s.aws    = aws;
        s.dws    = dws;
        s.err    = err;
        s.rdata  = rdata;
        q_addr.push_back(a);
        q_done.push_back(d);
        q_slv.push_back(s);
    endtask

    task automatic wait_nonseq();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.htrans_out == HTRANS_NONSEQ) seen = 1'b1;
        end
        chk("accept_seen", seen, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (q_done.size() != 0 || q_addr.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        chk("drain_done_q", q_done.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic single(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input int aws, input int dws,
                          input logic err, input logic [31:0] rdata);
        push_xfer(wr, addr, data, mask, aws, dws, err, rdata);
        bus.dmaddr_in    = addr;
        bus.dmdata_in    = data;
        bus.dmwr_mask_in = mask;
        bus.dmwr_req_in  = wr;
        bus.dmrd_req_in  = !wr;
        wait_nonseq();
        bus.dmwr_req_in  = 1'b0;
        bus.dmrd_req_in  = 1'b0;
        drain();
    endtask

    task automatic chk_reset_vals();
        chk("rst_htrans",   bus.htrans_out,   2'b00);
        chk("rst_haddr",    bus.haddr_out,    32'h0);
        chk("rst_hwrite",   bus.hwrite_out,   1'b0);
        chk("rst_hsize",    bus.hsize_out,    3'b000);
        chk("rst_hwdata",   bus.hwdata_out,   32'h0);
        chk("rst_rd_data",  bus.rd_data_out,  32'h0);
        chk("rst_rd_valid", bus.rd_valid_out, 1'b0);
        chk("rst_bus_err",  bus.bus_err_out,  1'b0);
    endtask

    // AHB slave model: wait states, response and read data come from q_slv.
    initial begin
        int       sl_st;
        int       cnt;
        slv_cfg_t c;
        sl_st = 0;
        cnt   = 0;
        c     = '{0, 0, 1'b0, 32'h0};
        bus.hready_in = 1'b1;
        bus.hresp_in  = 1'b0;
        bus.hrdata_in = 32'h0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                sl_st = 0;
                bus.hready_in = 1'b1;
                bus.hresp_in  = 1'b0;
            end else begin
                case (sl_st)
                    0: if (bus.htrans_out == HTRANS_NONSEQ) begin
                           if (q_slv.size() != 0) c = q_slv.pop_front();
                           else c = '{0, 0, 1'b0, 32'h0};
                           cnt = c.aws;
                           bus.hready_in = (cnt == 0);
                           sl_st = 1;
                       end
                    1: if (bus.hready_in) begin
                           cnt = c.dws;
                           bus.hready_in = (cnt == 0);
                           bus.hresp_in  = c.err;
                           bus.hrdata_in = c.rdata;
                           sl_st = 2;
                       end else begin
                           cnt--;
                           bus.hready_in = (cnt == 0);
                       end
                    default: if (bus.hready_in) begin
                           bus.hresp_in = 1'b0;
                           sl_st = 0;
                       end else begin
                           cnt--;
                           bus.hready_in = (cnt == 0);
                       end
                endcase
            end
        end
    end

    // Monitor: address phase, data phase and completion cycle, sampled at negedge.
    logic        mon_data = 1'b0;
    logic        mon_resp = 1'b0;
    int          hold_cnt = 0;
    logic [31:0] hold_addr = 32'h0;
    addr_exp_t   cur;
    done_exp_t   dx;

    always @(negedge clk) begin
        if (rst) begin
            mon_data = 1'b0;
            mon_resp = 1'b0;
            hold_cnt = 0;
        end else begin
            if (mon_resp) begin
                mon_resp = 1'b0;
                chk("done_expected", q_done.size() != 0, 1'b1);
                if (q_done.size() != 0) begin
                    dx = q_done.pop_front();
                    chk("rd_valid", bus.rd_valid_out, dx.rv);
                    chk("bus_err",  bus.bus_err_out,  dx.err);
                    if (dx.rv) chk("rd_data", bus.rd_data_out, dx.rdata);
                end
            end else begin
                chk("no_pulse", {bus.rd_valid_out, bus.bus_err_out}, 2'b00);
            end

            if (bus.htrans_out == HTRANS_NONSEQ) begin
                hold_cnt++;
                chk("stall_addr", bus.stall_out, 1'b1);
                if (hold_cnt == 1) hold_addr = bus.haddr_out;
                else chk("addr_held", bus.haddr_out, hold_addr);
                if (bus.hready_in) begin
                    chk("addr_expected", q_addr.size() != 0, 1'b1);
                    if (q_addr.size() != 0) begin
                        cur = q_addr.pop_front();
                        chk("haddr",  bus.haddr_out,  cur.haddr);
                        chk("hwrite", bus.hwrite_out, cur.hwrite);
                        chk("hsize",  bus.hsize_out,  cur.hsize);
                        chk("addr_phase_cycles", hold_cnt, cur.hold);
                        mon_data = 1'b1;
                    end
                    hold_cnt = 0;
                end
            end else if (mon_data) begin
                chk("htrans_data", bus.htrans_out, 2'b00);
                chk("stall_data",  bus.stall_out, 1'b1);
                if (bus.hready_in) begin
                    if (cur.hwrite) chk("hwdata", bus.hwdata_out, cur.hwdata);
                    mon_data = 1'b0;
                    mon_resp = 1'b1;
                end
            end else begin
                chk("stall_idle", bus.stall_out, bus.dmwr_req_in | bus.dmrd_req_in);
            end
        end
    end

    initial begin
        bus.dmaddr_in    = 32'h0;
        bus.dmdata_in    = 32'h0;
        bus.dmwr_mask_in = 4'h0;
        bus.dmwr_req_in  = 1'b0;
        bus.dmrd_req_in  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        chk("rst_stall", bus.stall_out, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // sb lane 1, then sw with address-phase wait states, then lw with data wait states
        single(1'b1, 32'h0000_0100, 32'h0000_AB00, 4'b0010, 0, 0, 1'b0, 32'h0);
        single(1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0000, 3, 0, 1'b0, 32'h0);
        single(1'b0, 32'h0000_0300, 32'h0,         4'b0000, 0, 2, 1'b0, 32'hDEAD_BEEF);

        // error responses on a halfword write and on a read
        single(1'b1, 32'h0000_0400, 32'hBEEF_0000, 4'b1100, 0, 1, 1'b1, 32'h0);
        single(1'b0, 32'h0000_0500, 32'h0,         4'b0000, 1, 0, 1'b1, 32'h5555_AAAA);

        // mask corner cases
        single(1'b1, 32'h0000_0700, 32'h00FF_00FF, 4'b0101, 0, 0, 1'b0, 32'h0);
        single(1'b1, 32'h0000_0704, 32'h7700_0000, 4'b1000, 0, 0, 1'b0, 32'h0);
        single(1'b1, 32'h0000_0800, 32'h0000_4321, 4'b0011, 1, 1, 1'b0, 32'h0);
        single(1'b1, 32'h0000_0808, 32'h0011_0000, 4'b0100, 0, 0, 1'b0, 32'h0);

        // simultaneous write and read: write goes first, read follows
        push_xfer(1'b1, 32'h0000_0600, 32'h0000_00CD, 4'b0001, 0, 0, 1'b0, 32'h0);
        push_xfer(1'b0, 32'h0000_0600, 32'h0,         4'b0001, 0, 1, 1'b0, 32'h0BAD_F00D);
        bus.dmaddr_in    = 32'h0000_0600;
        bus.dmdata_in    = 32'h0000_00CD;
        bus.dmwr_mask_in = 4'b0001;
        bus.dmwr_req_in  = 1'b1;
        bus.dmrd_req_in  = 1'b1;
        wait_nonseq();
        chk("first_is_write", bus.hwrite_out, 1'b1);
        bus.dmwr_req_in = 1'b0;
        wait_nonseq();
        chk("second_is_read", bus.hwrite_out, 1'b0);
        bus.dmrd_req_in = 1'b0;
        drain();

        // reset while a transfer sits in its data phase
        push_xfer(1'b1, 32'h0000_0900, 32'hCAFE_F00D, 4'b1111, 0, 5, 1'b0, 32'h0);
        bus.dmaddr_in    = 32'h0000_0900;
        bus.dmdata_in    = 32'hCAFE_F00D;
        bus.dmwr_mask_in = 4'b1111;
        bus.dmwr_req_in  = 1'b1;
        wait_nonseq();
        bus.dmwr_req_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_in_data", bus.stall_out, 1'b1);
        rst = 1'b1;
        q_addr.delete();
        q_done.delete();
        q_slv.delete();
        @(posedge clk); #1;
        chk_reset_vals();
        chk("rst_mid_stall", bus.stall_out, 1'b0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_htrans", bus.htrans_out, 2'b00);

        // a normal transfer still works after the abandoned one
        single(1'b0, 32'h0000_0A00, 32'h0, 4'b0000, 0, 0, 1'b0, 32'h1357_9BDF);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
